// File: rtl/l2_jtag_core_arbiter.sv
// l2_jtag_core_arbiter
//   Shares the single-port L2 SRAM between the JTAG debug bus master (M0)
//   and the core/data master (M1). Round-robin arbitration with a bounded
//   JTAG burst lock, out-of-range/misaligned error responses and a one-cycle
//   response pipeline that routes read data back to the granted master.
//
// Handshake: a master raises mX_req_i and holds we/addr/wdata/be stable
//   until mX_gnt_o (combinational, same cycle) is seen high; the transfer
//   completes on req & gnt. Exactly one mX_rvalid_o pulse follows on the
//   next cycle for every completed transfer, with mX_err_o/mX_rdata_o
//   qualified by it. There is no back-pressure on the response side.
//
// Ports:
//   clk_i, rst_n                 clock, asynchronous active-low reset
//   mX_req_i/we_i/addr_i/wdata_i/be_i   requester X (0 = JTAG, 1 = core)
//   m0_lock_i                    JTAG burst lock request
//   mX_gnt_o                     grant (combinational)
//   mX_rvalid_o/rdata_o/err_o    response, one cycle after the grant
//   mem_req_o/we_o/addr_o/wdata_o/be_o  L2 macro request (word address)
//   mem_rdata_i                  L2 read data, one cycle after mem_req_o
//   dbg_lock_state_o             lock FSM state (1 = LOCKED)
//
// Build option: define L2_ARB_JTAG_PRIO_EN to give M0 fixed priority over
//   M1; after MAX_LOCK consecutive contended M0 grants one M1 grant is
//   forced so the core cannot starve.
module l2_jtag_core_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int L2_WORDS = 16384,
   parameter int MAX_LOCK = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_n,
   input  logic                        m0_req_i,
   input  logic                        m0_we_i,
   input  logic [ADDR_W-1:0]           m0_addr_i,
   input  logic [31:0]                 m0_wdata_i,
   input  logic [3:0]                  m0_be_i,
   input  logic                        m0_lock_i,
   output logic                        m0_gnt_o,
   output logic                        m0_rvalid_o,
   output logic [31:0]                 m0_rdata_o,
   output logic                        m0_err_o,
   input  logic                        m1_req_i,
   input  logic                        m1_we_i,
   input  logic [ADDR_W-1:0]           m1_addr_i,
   input  logic [31:0]                 m1_wdata_i,
   input  logic [3:0]                  m1_be_i,
   output logic                        m1_gnt_o,
   output logic                        m1_rvalid_o,
   output logic [31:0]                 m1_rdata_o,
   output logic                        m1_err_o,
   output logic                        mem_req_o,
   output logic                        mem_we_o,
   output logic [$clog2(L2_WORDS)-1:0] mem_addr_o,
   output logic [31:0]                 mem_wdata_o,
   output logic [3:0]                  mem_be_o,
   input  logic [31:0]                 mem_rdata_i,
   output logic                        dbg_lock_state_o
);

   localparam int              MEM_AW     = $clog2(L2_WORDS);
   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(L2_WORDS) << 2;
   localparam logic [7:0]      MAX_LOCK_C = 8'(MAX_LOCK);
   localparam logic [31:0]     ERR_DATA   = 32'hDEAD_BEEF;

   typedef enum logic {LK_IDLE = 1'b0, LK_LOCKED = 1'b1} lock_state_e;

   lock_state_e       state_q, state_d;
   logic [7:0]        lock_cnt_q, lock_cnt_d;
   logic              gnt0, gnt1, any_gnt;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic [3:0]        sel_be;
   logic              addr_err;
   logic              rsp_valid_q, rsp_owner_q, rsp_err_q, rsp_we_q;
   logic [31:0]       rsp_data;

   // ---------------- arbitration ----------------
`ifdef L2_ARB_JTAG_PRIO_EN
   // force_m1_q: M0 has won MAX_LOCK contended grants in a row, M1 goes next.
   logic       force_m1_q;
   logic [7:0] streak_q;

   assign gnt0 = m0_req_i && !(m1_req_i && force_m1_q);

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         force_m1_q <= 1'b0;
         streak_q   <= 8'd0;
      end else if (gnt1) begin
         force_m1_q <= 1'b0;
         streak_q   <= 8'd0;
      end else if (gnt0 && m1_req_i) begin
         if (streak_q + 8'd1 >= MAX_LOCK_C) begin
            force_m1_q <= 1'b1;
            streak_q   <= 8'd0;
         end else begin
            streak_q   <= streak_q + 8'd1;
         end
      end
   end
`else
   // rr_q: 0 = M0 owns the next contended slot, 1 = M1 does.
   logic rr_q;
   logic lock_active;

   assign lock_active = (state_q == LK_LOCKED);
   assign gnt0 = m0_req_i && (!m1_req_i || lock_active || !rr_q);

   // After any grant the pointer moves to the master that was not granted.
   // Leaving LOCKED on the limit always coincides with an M0 grant, so this
   // also hands the following contended slot to M1.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n)       rr_q <= 1'b0;
      else if (any_gnt) rr_q <= gnt0;
   end
`endif

   assign gnt1    = m1_req_i && !gnt0;
   assign any_gnt = gnt0 || gnt1;
   assign m0_gnt_o = gnt0;
   assign m1_gnt_o = gnt1;

   // ---------------- lock FSM ----------------
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= LK_IDLE;
         lock_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      unique case (state_q)
         LK_IDLE: begin
            // With MAX_LOCK = 1 the first locked grant already hits the limit.
            if (gnt0 && m0_lock_i && (MAX_LOCK_C > 8'd1)) begin
               state_d    = LK_LOCKED;
               lock_cnt_d = 8'd1;
            end
         end
         LK_LOCKED: begin
            if (!m0_lock_i) begin
               state_d    = LK_IDLE;
               lock_cnt_d = 8'd0;
            end else if (gnt0) begin
               if (lock_cnt_q + 8'd1 >= MAX_LOCK_C) begin
                  state_d    = LK_IDLE;
                  lock_cnt_d = 8'd0;
               end else begin
                  lock_cnt_d = lock_cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d    = LK_IDLE;
            lock_cnt_d = 8'd0;
         end
      endcase
   end

   assign dbg_lock_state_o = (state_q == LK_LOCKED);

   // ---------------- request path to L2 ----------------
   assign sel_we    = gnt0 ? m0_we_i    : m1_we_i;
   assign sel_addr  = gnt0 ? m0_addr_i  : m1_addr_i;
   assign sel_wdata = gnt0 ? m0_wdata_i : m1_wdata_i;
   assign sel_be    = gnt0 ? m0_be_i    : m1_be_i;

   // Out-of-range and misaligned accesses are answered locally.
   assign addr_err = ({1'b0, sel_addr} >= ADDR_LIMIT) || (sel_addr[1:0] != 2'b00);

   assign mem_req_o   = any_gnt && !addr_err;
   assign mem_we_o    = mem_req_o && sel_we;
   assign mem_addr_o  = mem_req_o ? sel_addr[2 +: MEM_AW] : '0;
   assign mem_wdata_o = mem_req_o ? sel_wdata : 32'd0;
   assign mem_be_o    = mem_req_o ? sel_be : 4'd0;

   // ---------------- response pipeline ----------------
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_owner_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_we_q    <= 1'b0;
      end else begin
         rsp_valid_q <= any_gnt;
         if (any_gnt) begin
            rsp_owner_q <= gnt1;
            rsp_err_q   <= addr_err;
            rsp_we_q    <= sel_we;
         end
      end
   end

   assign rsp_data = rsp_err_q ? ERR_DATA : (rsp_we_q ? 32'd0 : mem_rdata_i);

   assign m0_rvalid_o = rsp_valid_q && !rsp_owner_q;
   assign m1_rvalid_o = rsp_valid_q &&  rsp_owner_q;
   assign m0_err_o    = m0_rvalid_o && rsp_err_q;
   assign m1_err_o    = m1_rvalid_o && rsp_err_q;
   assign m0_rdata_o  = m0_rvalid_o ? rsp_data : 32'd0;
   assign m1_rdata_o  = m1_rvalid_o ? rsp_data : 32'd0;

endmodule
